// File: rtl/seg7_pkg.sv
// Shared types and width helpers for the 7-segment scan controller.
package seg7_pkg;

  localparam int BCD_W = 4;

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_lzb_mask.sv
// Leading-zero blank mask: digit k is blanked when it and every higher nibble are zero.
module seg7_lzb_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [BCD_W*NUM_DIGITS-1:0] disp,
  output logic [NUM_DIGITS-1:0]       mask
);

  logic nz;

  // Suffix-OR from the most significant digit down; digit 0 always shows.
  always_comb begin
    mask = '0;
    nz   = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nz      = nz | (|disp[k*BCD_W +: BCD_W]);
      mask[k] = (k != 0) && !nz;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned double buffering.
//   state | meaning
//   DEAD  | slot start, all digit enables off (anti-ghosting gap)
//   SHOW  | current digit enabled, bcd_out/blank held for the slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLK_DIV       = 1000,
  parameter int DEAD_CYC      = 2,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        load_valid,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
  output logic                        load_ready,
  output logic [BCD_W-1:0]            bcd_out,
  output logic                        blank,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        frame_done
);

  localparam int TICK_W = width_of(CLK_DIV);
  localparam int IDX_W  = width_of(NUM_DIGITS);
  localparam int WORD_W = BCD_W * NUM_DIGITS;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(CLK_DIV - 2);
  // DEAD_CYC >= 1: the SHOW edge is taken from the last DEAD cycle.
  localparam logic [TICK_W-1:0] TICK_SHOW = TICK_W'(DEAD_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t          state;
  logic [TICK_W-1:0]    tick;
  logic [IDX_W-1:0]     idx;
  logic [WORD_W-1:0]    disp_reg;
  logic [WORD_W-1:0]    pend_reg;
  logic                 pend_valid;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                 xfer;
  logic                 tick_wrap;
  logic                 last_digit;

  assign xfer       = load_valid && load_ready;
  assign tick_wrap  = (tick == TICK_LAST);
  assign last_digit = (idx == IDX_LAST);

  seg7_lzb_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lzb (
    .disp(disp_reg),
    .mask(lz_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DEAD;
      tick       <= '0;
      idx        <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
      load_ready <= 1'b1;
      digit_en   <= '0;
      bcd_out    <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= DEAD;
      tick       <= '0;
      idx        <= '0;
      digit_en   <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
      if (pend_valid) begin
        disp_reg   <= pend_reg;
        pend_valid <= 1'b0;
      end else if (xfer) begin
        disp_reg <= load_data;
      end
    end else begin
      tick       <= tick_wrap ? '0 : tick + TICK_W'(1);
      frame_done <= last_digit && (tick == TICK_PRE);
      if (tick_wrap) begin
        idx <= last_digit ? '0 : idx + IDX_W'(1);
      end

      if (tick == TICK_SHOW) begin
        state    <= SHOW;
        digit_en <= NUM_DIGITS'(1) << idx;
        bcd_out  <= disp_reg[32'(idx)*BCD_W +: BCD_W];
        blank    <= BLANK_LEADING && lz_mask[idx];
      end else if (tick_wrap && state == SHOW) begin
        state    <= DEAD;
        digit_en <= '0;
      end

      // Display word only changes on the frame boundary, so a frame never tears.
      if (frame_done) begin
        if (pend_valid) begin
          disp_reg   <= pend_reg;
          pend_valid <= 1'b0;
          load_ready <= 1'b1;
        end else if (xfer) begin
          disp_reg <= load_data;
        end
      end else if (xfer) begin
        pend_reg   <= load_data;
        pend_valid <= 1'b1;
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-level reference model queues expected digit slots.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int CD = 8;
  localparam int DC = 2;
  localparam int FR = ND * CD;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          load_valid;
  logic [15:0]   load_data;
  logic          load_ready;
  logic [3:0]    bcd_out;
  logic          blank;
  logic [ND-1:0] digit_en;
  logic          frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND),
    .CLK_DIV(CD),
    .DEAD_CYC(DC),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .bcd_out(bcd_out),
    .blank(blank),
    .digit_en(digit_en),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] bcd;
    logic       blk;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: displayed word, pending word, position within the frame.
  logic [15:0] md;
  logic [15:0] mp;
  bit          mpv;
  int          mc;
  bit          mdis;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic int nib(logic [15:0] w, int k);
    return int'((w >> (4 * k)) & 16'hF);
  endfunction

  function automatic bit lz(logic [15:0] w, int k);
    return (k > 0) && ((w >> (4 * k)) == 16'h0);
  endfunction

  initial begin : model
    bit   xfer;
    exp_t e;
    md = '0; mp = '0; mpv = 0; mc = 0; mdis = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        md = '0; mpv = 0; mc = 0; mdis = 0;
      end else begin
        xfer = load_valid && !mpv;
        if (!enable) begin
          if (mpv) begin md = mp; mpv = 0; end
          else if (xfer) md = load_data;
          mc = 0;
        end else begin
          if (mc == FR - 1) begin
            if (mpv) begin md = mp; mpv = 0; end
            else if (xfer) md = load_data;
          end else if (xfer) begin
            mp = load_data; mpv = 1;
          end
          mc = (mc + 1) % FR;
        end
        mdis = !enable;
        if (mc % CD >= DC) begin
          e.en  = 4'(1 << (mc / CD));
          e.bcd = 4'(nib(md, mc / CD));
          e.blk = lz(md, mc / CD);
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_digit_en", int'(digit_en), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_bcd_out", int'(bcd_out), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        exp_q.delete();
      end else begin
        chk("frame_done", int'(frame_done), int'(mc == FR - 1));
        chk("load_ready", int'(load_ready), int'(!mpv));
        if (mdis) chk("blank_disabled", int'(blank), 1);
        if (digit_en != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_digit_en", int'(digit_en), 0);
          end else begin
            e = exp_q.pop_front();
            chk("digit_en", int'(digit_en), int'(e.en));
            chk("bcd_out", int'(bcd_out), int'(e.bcd));
            chk("blank", int'(blank), int'(e.blk));
          end
        end
        if (exp_q.size() != 0) begin
          chk("missing_digit_en", int'(digit_en), int'(exp_q[0].en));
          exp_q.delete();
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(logic [15:0] w);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    load_valid = 1'b1;
    load_data  = w;
    while (!ok && n < 4 * FR) begin
      ok = load_ready;
      cyc(1);
      n++;
    end
    load_valid = 1'b0;
    if (!ok) chk("load_timeout", 0, 1);
  endtask

  task automatic wait_mc(int target);
    int n;
    n = 0;
    while (mc != target && n < 4 * FR) begin
      cyc(1);
      n++;
    end
    if (mc != target) chk("wait_timeout", mc, target);
  endtask

  initial begin : stim
    logic [15:0] w;
    int          r;
    rst = 1'b1; enable = 1'b1; load_valid = 1'b0; load_data = '0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("first_slot_digit_en", int'(digit_en), 1);
    chk("first_slot_bcd_out", int'(bcd_out), 0);
    chk("first_slot_blank", int'(blank), 0);

    load_word(16'h1234);  cyc(2 * FR);
    load_word(16'h0050);  cyc(2 * FR);
    load_word(16'h0000);  cyc(2 * FR);
    load_word(16'h1111);
    load_word(16'h2222);  cyc(2 * FR);
    load_word(16'h9A00);  cyc(2 * FR);

    // Reset at tick 5 of digit 2 with a word still pending.
    wait_mc(2);
    load_word(16'h5678);
    wait_mc(2 * CD + 5);
    chk("pre_rst_digit_en", int'(digit_en), 4);
    rst = 1'b1;
    #1;
    chk("async_rst_digit_en", int'(digit_en), 0);
    chk("async_rst_load_ready", int'(load_ready), 1);
    cyc(2);
    rst = 1'b0;
    cyc(FR);

    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    cyc(FR);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      enable = (r != 0);
      rst    = (r == 1);
      load_valid = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++)
        w[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
      load_data = w;
      cyc(1);
    end
    rst = 1'b0; enable = 1'b1; load_valid = 1'b0;
    cyc(2 * FR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
